ct_spsram_param_ift: RTL and testbench
======================================

# ct_spsram_param_ift

Parametrised single-port synchronous SRAM for the C910 memory macros, generalising the fixed 4096x32 wrapper.
- Configurable depth, data width and write-lane granularity.
- Built-in post-reset zero-initialisation sequencer with a BUSY indication.
- A real taint shadow array (the existing wrapper ties Q_t0 to zero) for information-flow-tracked simulation.
- Optional output pipeline register.
- Sits between cache/TLB data-path logic and the storage array.

## Interface
Parameters:
- ADDR_WIDTH, 12: address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: word width.
- WE_WIDTH, 32: write-lane count; must divide DATA_WIDTH; LANE = DATA_WIDTH/WE_WIDTH bits per lane.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- CEN  in  1  chip enable, active low.
- GWEN  in  1  global write enable, active low (0 = write, 1 = read).
- A  in  ADDR_WIDTH  address.
- D  in  DATA_WIDTH  write data.
- WEN  in  WE_WIDTH  per-lane write enable, active low.
- Q  out  DATA_WIDTH  read data.
- BUSY  out  1  high while the init sequencer owns the array.
- A_t0, CEN_t0, GWEN_t0, D_t0, WEN_t0  in  taint of the like-named input, same width.
- Q_t0  out  DATA_WIDTH  taint of Q.

## Operation
- Init FSM, states INIT and READY.
  - RST forces INIT with counter = 0.
  - In INIT: each cycle writes 0 to data[cnt] and shadow[cnt], then cnt += 1.
  - At cnt == DEPTH-1 the FSM moves to READY.
  - RST asserted in any state restarts INIT from cnt = 0.
- While BUSY: user accesses are ignored; Q and Q_t0 hold their values.
- Write (READY, CEN=0, GWEN=0):
  - Bit i is written with D[i] iff WEN[i/LANE] == 0.
  - Q and Q_t0 hold; there is no write-through.
- Read (READY, CEN=0, GWEN=1): Q = data[A].
- Idle (CEN=1): Q holds.
- Taint, write: ctl = CEN_t0 | GWEN_t0 | (|A_t0). For each written bit, shadow[i] = D_t0[i] | ctl.
  - Any lane with WEN_t0 set additionally gets its shadow bits set to 1, whether or not it was written.
- Taint, read: Q_t0 = shadow[A] | {DATA_WIDTH{ctl}}.
- Taint, otherwise: if CEN=1 and CEN_t0=1, Q_t0 becomes all-ones (Q might have changed); else Q_t0 holds.
- Address range: the address is always in range (DEPTH = 2**ADDR_WIDTH); no wrap logic.

## Timing
- Reset values: Q = 0, Q_t0 = 0, BUSY = 1.
- Init duration: BUSY stays high for DEPTH cycles after the first cycle with RST low, then falls.
- First user access is accepted in the first cycle with BUSY = 0.
- Read latency: 1 cycle (Q valid at the edge after the access cycle); 2 cycles with the output register enabled.
- Back-to-back accesses: one access per cycle at full throughput.
- Read after write to the same address in the next cycle returns the new data.
- Same-cycle RST and access: RST wins; the access is dropped.

## Configuration
- Macro: CT_SPSRAM_OUT_REG_EN.
- Defined: Q and Q_t0 pass through an extra register stage.
  - Read latency becomes 2.
  - The stage register resets to 0.
  - The hold/idle rules above apply at the array output; the stage always samples the array output.
- Undefined: the array output register drives Q and Q_t0 directly; latency 1.

## Structure
- Package ct_spsram_pkg holds:
  - the state enum (INIT, READY);
  - a lane-mask expansion function (WE_WIDTH to DATA_WIDTH bit mask);
  - default parameter constants.
- Sub-module ct_spsram_init_fsm: counter, state register and BUSY; outputs the init write enable and address to the top-level array mux.
- The data and shadow arrays live in the top level as two behavioural arrays with identical addressing.

## Test plan
- Init with ADDR_WIDTH=4: pulse RST for 2 cycles -> BUSY high for exactly 16 cycles after RST falls; reading every address afterwards returns Q = 0 and Q_t0 = 0.
- Lane write with WE_WIDTH=4, DATA_WIDTH=32: write A=3, D=0xAABBCCDD, WEN=4'b1010, then write A=3, D=0x11223344, WEN=4'b0101 -> read A=3 gives Q = 0x11BB33DD.
- Read/write pipeline: alternating write A=5, D=0x5 / read A=5 every cycle -> each read returns 0x5 one cycle later (two cycles with CT_SPSRAM_OUT_REG_EN); Q holds during the write cycles.
- Taint, data: write A=1 with D_t0 = 0x000000FF, then read with clean controls -> Q_t0 = 0x000000FF.
- Taint, control: read A=1 with A_t0[0]=1 -> Q_t0 = 0xFFFFFFFF. Idle cycle with CEN=1, CEN_t0=1 -> Q_t0 = 0xFFFFFFFF.
- Reset mid-init: assert RST at init cycle 7 -> counter restarts; BUSY falls DEPTH cycles after the second RST release; a write issued during BUSY is not visible on a later read.

Source files
------------

// File: rtl/ct_spsram_pkg.sv
// Shared types, defaults and the write-lane expansion helper for ct_spsram_param_ift.
// Optional output stage is selected in the top level by CT_SPSRAM_OUT_REG_EN.
package ct_spsram_pkg;

   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_WE_WIDTH   = 32;
   localparam int MAX_DW         = 1024;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } init_state_e;

   // Spreads one active-high enable per lane across the lane's bits.
   function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_DW-1:0] lane_en,
                                                   input int lane_bits);
      logic [MAX_DW-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_DW; i++) begin
         m[i] = lane_en[i / lane_bits];
      end
      return m;
   endfunction

endpackage

// File: rtl/ct_spsram_init_fsm.sv
// Post-reset zero-fill sequencer: walks every address once, then hands the array to the user.
import ct_spsram_pkg::*;

module ct_spsram_init_fsm #(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   output logic                  o_busy,
   output logic                  o_init_we,
   output logic [ADDR_WIDTH-1:0] o_init_addr
);

   init_state_e           r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_busy;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= INIT;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else if (r_state == INIT) begin
         r_cnt <= r_cnt + ADDR_WIDTH'(1);
         // Last address (DEPTH-1) is written in the same cycle the FSM releases the array.
         if (r_cnt == '1) begin
            r_state <= READY;
            r_busy  <= 1'b0;
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_init_we   = r_busy;
   assign o_init_addr = r_cnt;

endmodule

// File: rtl/ct_spsram_param_ift.sv
// Parametrised single-port SRAM with zero-init sequencer and a taint shadow array.
// Define CT_SPSRAM_OUT_REG_EN to add an output register stage (read latency 2).
import ct_spsram_pkg::*;

module ct_spsram_param_ift #(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WE_WIDTH   = DEF_WE_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic [WE_WIDTH-1:0]   WEN,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  BUSY,
   input  logic [ADDR_WIDTH-1:0] A_t0,
   input  logic                  CEN_t0,
   input  logic                  GWEN_t0,
   input  logic [DATA_WIDTH-1:0] D_t0,
   input  logic [WE_WIDTH-1:0]   WEN_t0,
   output logic [DATA_WIDTH-1:0] Q_t0
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LANE  = DATA_WIDTH / WE_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem    [DEPTH];
   logic [DATA_WIDTH-1:0] r_shadow [DEPTH];
   logic [DATA_WIDTH-1:0] r_q;
   logic [DATA_WIDTH-1:0] r_q_t0;

   logic                  w_busy;
   logic                  w_init_we;
   logic [ADDR_WIDTH-1:0] w_init_addr;
   logic                  w_ctl_t0;
   logic                  w_acc;
   logic                  w_wr;
   logic                  w_rd;
   logic [WE_WIDTH-1:0]   w_wen_en;
   logic [DATA_WIDTH-1:0] w_wmask;
   logic [DATA_WIDTH-1:0] w_tmask;
   logic [DATA_WIDTH-1:0] w_mem_wdata;
   logic [DATA_WIDTH-1:0] w_shd_wdata;

   ct_spsram_init_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_init_fsm (
      .i_clk       (CLK),
      .i_rst       (RST),
      .o_busy      (w_busy),
      .o_init_we   (w_init_we),
      .o_init_addr (w_init_addr)
   );

   // Reset outranks any user access presented in the same cycle.
   assign w_acc    = !RST && !w_busy && !CEN;
   assign w_wr     = w_acc && !GWEN;
   assign w_rd     = w_acc && GWEN;
   assign w_ctl_t0 = CEN_t0 | GWEN_t0 | (|A_t0);

   assign w_wen_en = ~WEN;
   assign w_wmask  = DATA_WIDTH'(lane_mask(MAX_DW'(w_wen_en), LANE));
   assign w_tmask  = DATA_WIDTH'(lane_mask(MAX_DW'(WEN_t0), LANE));

   assign w_mem_wdata = (r_mem[A] & ~w_wmask) | (D & w_wmask);
   assign w_shd_wdata = (r_shadow[A] & ~w_wmask)
                      | ((D_t0 | {DATA_WIDTH{w_ctl_t0}}) & w_wmask)
                      | w_tmask;

   // NOTE: the arrays carry no reset; the init sequencer clears them, which keeps them mappable to RAM.
   always_ff @(posedge CLK) begin
      if (!RST && w_init_we) begin
         r_mem[w_init_addr]    <= '0;
         r_shadow[w_init_addr] <= '0;
      end else if (w_wr) begin
         r_mem[A]    <= w_mem_wdata;
         r_shadow[A] <= w_shd_wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_q    <= '0;
         r_q_t0 <= '0;
      end else if (w_rd) begin
         r_q    <= r_mem[A];
         r_q_t0 <= r_shadow[A] | {DATA_WIDTH{w_ctl_t0}};
      end else if (!w_busy && CEN && CEN_t0) begin
         r_q_t0 <= '1;
      end
   end

`ifdef CT_SPSRAM_OUT_REG_EN
   logic [DATA_WIDTH-1:0] r_q_pipe;
   logic [DATA_WIDTH-1:0] r_q_t0_pipe;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_q_pipe    <= '0;
         r_q_t0_pipe <= '0;
      end else begin
         r_q_pipe    <= r_q;
         r_q_t0_pipe <= r_q_t0;
      end
   end

   assign Q    = r_q_pipe;
   assign Q_t0 = r_q_t0_pipe;
`else
   assign Q    = r_q;
   assign Q_t0 = r_q_t0;
`endif

   assign BUSY = w_busy;

endmodule

// File: tb/tb_ct_spsram_param_ift.sv
// Directed bench for ct_spsram_param_ift (16x32, four byte lanes); honours CT_SPSRAM_OUT_REG_EN.
module tb_ct_spsram_param_ift;

`ifdef CT_SPSRAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        CEN;
   logic        GWEN;
   logic [3:0]  A;
   logic [31:0] D;
   logic [3:0]  WEN;
   logic [31:0] Q;
   logic        BUSY;
   logic [3:0]  A_t0;
   logic        CEN_t0;
   logic        GWEN_t0;
   logic [31:0] D_t0;
   logic [3:0]  WEN_t0;
   logic [31:0] Q_t0;

   int n_vec = 0;
   int n_err = 0;

   ct_spsram_param_ift #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST), .CEN(CEN), .GWEN(GWEN), .A(A), .D(D), .WEN(WEN),
      .Q(Q), .BUSY(BUSY), .A_t0(A_t0), .CEN_t0(CEN_t0), .GWEN_t0(GWEN_t0),
      .D_t0(D_t0), .WEN_t0(WEN_t0), .Q_t0(Q_t0)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_idle();
      CEN = 1'b1; GWEN = 1'b1; A = '0; D = '0; WEN = '1;
      A_t0 = '0; CEN_t0 = 1'b0; GWEN_t0 = 1'b0; D_t0 = '0; WEN_t0 = '0;
   endtask

   task automatic do_read(input logic [3:0] addr, input logic [3:0] a_t0);
      CEN = 1'b0; GWEN = 1'b1; A = addr; A_t0 = a_t0;
      step();
      set_idle();
      for (int i = 1; i < LAT; i++) step();
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] wen,
                           input logic [31:0] dt0, input logic [3:0] went0, input logic gwent0);
      CEN = 1'b0; GWEN = 1'b0; A = addr; D = d; WEN = wen;
      D_t0 = dt0; WEN_t0 = went0; GWEN_t0 = gwent0;
      step();
      set_idle();
   endtask

   task automatic test_reset();
      int n;
      set_idle();
      RST = 1'b1;
      step(); step();
      n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", BUSY); end
      n_vec++; if (Q !== 32'h0) begin n_err++; $display("FAIL reset_q got %h want 0", Q); end
      n_vec++; if (Q_t0 !== 32'h0) begin n_err++; $display("FAIL reset_qt0 got %h want 0", Q_t0); end
      RST = 1'b0;
      n = 0;
      while (n < 100) begin
         step();
         n++;
         if (BUSY !== 1'b1) break;
      end
      n_vec++; if (n !== 16) begin n_err++; $display("FAIL init_len got %0d cycles want 16", n); end
   endtask

   task automatic test_init_zero();
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), 4'h0);
         n_vec++; if (Q !== 32'h0) begin n_err++; $display("FAIL init_q[%0d] got %h want 0", a, Q); end
         n_vec++; if (Q_t0 !== 32'h0) begin n_err++; $display("FAIL init_qt0[%0d] got %h want 0", a, Q_t0); end
      end
   endtask

   task automatic test_lane_write();
      do_write(4'd3, 32'hAABBCCDD, 4'b1010, 32'h0, 4'h0, 1'b0);
      n_vec++; if (Q !== 32'h0) begin n_err++; $display("FAIL write_hold_q got %h want 0", Q); end
      do_write(4'd3, 32'h11223344, 4'b0101, 32'h0, 4'h0, 1'b0);
      do_read(4'd3, 4'h0);
      n_vec++; if (Q !== 32'h11BB33DD) begin n_err++; $display("FAIL lane_q got %h want 11bb33dd", Q); end
      n_vec++; if (Q_t0 !== 32'h0) begin n_err++; $display("FAIL lane_qt0 got %h want 0", Q_t0); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] dv [3];
      logic [31:0] mq, mp, exp_q;
      dv[0] = 32'h5; dv[1] = 32'h50; dv[2] = 32'h500;
      mq = 32'h11BB33DD;
      mp = 32'h11BB33DD;
      for (int s = 0; s < 7; s++) begin
         if (s == 6) begin
            set_idle();
         end else begin
            CEN = 1'b0; A = 4'd5; WEN = 4'h0;
            GWEN = s[0];
            D = dv[s / 2];
         end
         step();
         mp = mq;
         if (s < 6 && s[0]) mq = dv[s / 2];
         exp_q = (LAT == 1) ? mq : mp;
         n_vec++; if (Q !== exp_q) begin n_err++; $display("FAIL b2b_q[%0d] got %h want %h", s, Q, exp_q); end
      end
      set_idle();
   endtask

   task automatic test_taint_data();
      do_write(4'd1, 32'h12345678, 4'h0, 32'h000000FF, 4'h0, 1'b0);
      do_read(4'd1, 4'h0);
      n_vec++; if (Q !== 32'h12345678) begin n_err++; $display("FAIL tdata_q got %h want 12345678", Q); end
      n_vec++; if (Q_t0 !== 32'h000000FF) begin n_err++; $display("FAIL tdata_qt0 got %h want 000000ff", Q_t0); end
   endtask

   task automatic test_taint_control();
      do_read(4'd1, 4'h1);
      n_vec++; if (Q_t0 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL taddr_qt0 got %h want ffffffff", Q_t0); end
      do_read(4'd1, 4'h0);
      n_vec++; if (Q_t0 !== 32'h000000FF) begin n_err++; $display("FAIL tclean_qt0 got %h want 000000ff", Q_t0); end
      CEN = 1'b1; CEN_t0 = 1'b1;
      for (int i = 0; i < LAT; i++) step();
      set_idle();
      n_vec++; if (Q_t0 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL tcen_qt0 got %h want ffffffff", Q_t0); end
      n_vec++; if (Q !== 32'h12345678) begin n_err++; $display("FAIL tcen_q got %h want 12345678", Q); end
   endtask

   task automatic test_taint_lanes();
      do_write(4'd2, 32'h0, 4'b1110, 32'h0, 4'b0100, 1'b0);
      do_read(4'd2, 4'h0);
      n_vec++; if (Q_t0 !== 32'h00FF0000) begin n_err++; $display("FAIL twen_qt0 got %h want 00ff0000", Q_t0); end
      do_write(4'd4, 32'hCAFEF00D, 4'h0, 32'h0, 4'h0, 1'b1);
      do_read(4'd4, 4'h0);
      n_vec++; if (Q !== 32'hCAFEF00D) begin n_err++; $display("FAIL tgwen_q got %h want cafef00d", Q); end
      n_vec++; if (Q_t0 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL tgwen_qt0 got %h want ffffffff", Q_t0); end
   endtask

   task automatic test_reset_mid_init();
      int n;
      set_idle();
      RST = 1'b1;
      step();
      RST = 1'b0;
      for (int i = 0; i < 7; i++) step();
      RST = 1'b1;
      CEN = 1'b0; GWEN = 1'b0; A = 4'd7; D = 32'h77777777; WEN = 4'h0;
      step();
      set_idle();
      n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", BUSY); end
      n_vec++; if (Q !== 32'h0) begin n_err++; $display("FAIL mid_q got %h want 0", Q); end
      RST = 1'b0;
      CEN = 1'b0; GWEN = 1'b0; A = 4'd6; D = 32'hDEADBEEF; WEN = 4'h0;
      n = 0;
      while (n < 100) begin
         step();
         n++;
         if (n == 3) set_idle();
         if (BUSY !== 1'b1) break;
      end
      set_idle();
      n_vec++; if (n !== 16) begin n_err++; $display("FAIL mid_init_len got %0d cycles want 16", n); end
      do_read(4'd6, 4'h0);
      n_vec++; if (Q !== 32'h0) begin n_err++; $display("FAIL busy_write_q got %h want 0", Q); end
      do_read(4'd3, 4'h0);
      n_vec++; if (Q !== 32'h0) begin n_err++; $display("FAIL reinit_q got %h want 0", Q); end
      do_read(4'd1, 4'h0);
      n_vec++; if (Q_t0 !== 32'h0) begin n_err++; $display("FAIL reinit_qt0 got %h want 0", Q_t0); end
   endtask

   initial begin
      RST = 1'b1;
      set_idle();
      test_reset();
      test_init_zero();
      test_lane_write();
      test_back_to_back();
      test_taint_data();
      test_taint_control();
      test_taint_lanes();
      test_reset_mid_init();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
